wb_serial_master: RTL

Wishbone initiator driven by a byte-stream command protocol: it turns bytes from a UART receiver into single-word Wishbone reads and writes, and returns response bytes to a UART transmitter. It lets a host load and inspect BRAM, SDRAM and the memory-mapped peripherals over the serial port. It is a second bus master alongside the processor, placed in front of the slave arbiter through a master-select mux.

---
 rtl/wb_serial_pkg.sv | 40 ++++
 rtl/wb_serial_timeout.sv | 34 +++
 rtl/wb_serial_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_serial_pkg.sv
// Shared types and byte constants for the serial-command Wishbone master.
package wb_serial_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WB_REQ,
        ST_WB_WAIT,
        ST_RESP
    } state_e;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
    localparam logic [BYTE_W-1:0] CMD_NEXT  = 8'h4E;

    localparam logic [BYTE_W-1:0] RSP_OK  = 8'h4B;
    localparam logic [BYTE_W-1:0] RSP_ERR = 8'h45;
    localparam logic [BYTE_W-1:0] RSP_UNK = 8'h3F;

    // Bus request payload assembled from the command bytes
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              we;
    } wb_req_t;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic logic is_next_cmd(input logic [BYTE_W-1:0] b);
        return b == CMD_NEXT;
    endfunction

endpackage

// File: rtl/wb_serial_timeout.sv
// Loadable down-counter: i_clear reloads, i_en counts down, terminal when zero.
module wb_serial_timeout #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_terminal_c
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = i_load_val;
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_terminal_c = (count_q == '0);

endmodule

// File: rtl/wb_serial_master.sv
// Byte-stream command interpreter driving single Wishbone reads/writes.
// Optional 'N' (write to last address + 4) enabled by WB_SERIAL_AUTOINC_EN.
module wb_serial_master
    import wb_serial_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned WB_TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [WORD_W-1:0] o_wb_addr,
    output logic [WORD_W-1:0] o_wb_data,
    output logic [SEL_W-1:0]  o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic [WORD_W-1:0] i_wb_data,
    output logic              o_busy
);

    localparam int unsigned IB_W  = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned WBT_W = cnt_width(WB_TIMEOUT);
    // Loaded with N-1 so the terminal flag is seen in the Nth counted cycle
    localparam logic [IB_W-1:0]  IB_LOAD  = IB_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WBT_W-1:0] WBT_LOAD = WBT_W'(WB_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] cmd_q, cmd_d;
    wb_req_t           req_q, req_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [1:0]        rsp_left_q, rsp_left_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
`ifdef WB_SERIAL_AUTOINC_EN
    logic [WORD_W-1:0] last_addr_q, last_addr_d;
`endif

    logic rx_last_c;
    logic is_addr_cmd_c;
    logic is_next_cmd_c;
    logic wb_done_c;
    logic tx_fire_c;
    logic ib_clear_c, ib_en_c, ib_term_c;
    logic wb_clear_c, wb_en_c, wb_term_c;

    assign rx_last_c     = i_rx_valid && (byte_cnt_q == 2'd3);
    assign is_addr_cmd_c = (i_rx_data == CMD_WRITE) || (i_rx_data == CMD_READ);
`ifdef WB_SERIAL_AUTOINC_EN
    assign is_next_cmd_c = is_next_cmd(i_rx_data);
`else
    assign is_next_cmd_c = 1'b0;
`endif
    // An ack alongside stall cannot belong to this request, so it is ignored
    assign wb_done_c = ((state_q == ST_WB_REQ) && !i_wb_stall && i_wb_ack)
                    || ((state_q == ST_WB_WAIT) && i_wb_ack);
    assign tx_fire_c = tx_valid_q && i_tx_ready;

    assign ib_clear_c = i_rx_valid && (state_q inside {ST_IDLE, ST_ADDR, ST_DATA});
    assign ib_en_c    = !i_rx_valid && (state_q inside {ST_ADDR, ST_DATA});
    assign wb_clear_c = (state_q != ST_WB_REQ) && (state_d == ST_WB_REQ);
    assign wb_en_c    = state_q inside {ST_WB_REQ, ST_WB_WAIT};

    wb_serial_timeout #(.WIDTH(IB_W)) u_ib_timeout (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (ib_clear_c),
        .i_en         (ib_en_c),
        .i_load_val   (IB_LOAD),
        .o_terminal_c (ib_term_c)
    );

    wb_serial_timeout #(.WIDTH(WBT_W)) u_wb_timeout (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (wb_clear_c),
        .i_en         (wb_en_c),
        .i_load_val   (WBT_LOAD),
        .o_terminal_c (wb_term_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (is_addr_cmd_c) begin
                        state_d = ST_ADDR;
                    end else if (is_next_cmd_c) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_last_c) begin
                    state_d = (cmd_q == CMD_WRITE) ? ST_DATA : ST_WB_REQ;
                end else if (!i_rx_valid && ib_term_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_last_c) begin
                    state_d = ST_WB_REQ;
                end else if (!i_rx_valid && ib_term_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB_REQ, ST_WB_WAIT: begin
                if (wb_done_c || wb_term_c) begin
                    state_d = ST_RESP;
                end else if ((state_q == ST_WB_REQ) && !i_wb_stall) begin
                    state_d = ST_WB_WAIT;
                end
            end
            ST_RESP: begin
                if (tx_fire_c && (rsp_left_q == 2'd0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_d      = cmd_q;
        req_d      = req_q;
        byte_cnt_d = byte_cnt_q;
        rsp_left_d = rsp_left_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
`ifdef WB_SERIAL_AUTOINC_EN
        last_addr_d = last_addr_q;
`endif
        cyc_d  = state_d inside {ST_WB_REQ, ST_WB_WAIT};
        stb_d  = (state_d == ST_WB_REQ);
        busy_d = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                byte_cnt_d = 2'd0;
                if (i_rx_valid) begin
                    cmd_d    = i_rx_data;
                    req_d.we = (i_rx_data != CMD_READ);
`ifdef WB_SERIAL_AUTOINC_EN
                    if (is_next_cmd_c) begin
                        req_d.addr = last_addr_q + WORD_W'(4);
                    end
`endif
                    if (state_d == ST_RESP) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = RSP_UNK;
                        rsp_left_d = 2'd0;
                    end
                end
            end
            ST_ADDR: begin
                if (i_rx_valid) begin
                    req_d.addr = {req_q.addr[WORD_W-BYTE_W-1:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end else if (state_d == ST_IDLE) begin
                    byte_cnt_d = 2'd0;
                end
            end
            ST_DATA: begin
                if (i_rx_valid) begin
                    req_d.data = {req_q.data[WORD_W-BYTE_W-1:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end else if (state_d == ST_IDLE) begin
                    byte_cnt_d = 2'd0;
                end
            end
            ST_WB_REQ, ST_WB_WAIT: begin
                if (state_d == ST_RESP) begin
                    tx_valid_d = 1'b1;
                    rsp_left_d = 2'd0;
                    if (wb_done_c) begin
`ifdef WB_SERIAL_AUTOINC_EN
                        last_addr_d = {req_q.addr[WORD_W-1:2], 2'b00};
`endif
                        if (req_q.we) begin
                            tx_data_d = RSP_OK;
                        end else begin
                            req_d.data = i_wb_data;
                            tx_data_d  = i_wb_data[WORD_W-1:WORD_W-BYTE_W];
                            rsp_left_d = 2'd3;
                        end
                    end else begin
                        tx_data_d = RSP_ERR;
                    end
                end
            end
            ST_RESP: begin
                // Read bytes shift out MSB first with one idle cycle between them
                if (tx_fire_c) begin
                    tx_valid_d = 1'b0;
                    if (rsp_left_q != 2'd0) begin
                        req_d.data = {req_q.data[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
                        rsp_left_d = rsp_left_q - 2'd1;
                    end
                end else if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = req_q.data[WORD_W-1:WORD_W-BYTE_W];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_d_unused_guard: begin end
            cmd_q      <= '0;
            req_q      <= '0;
            byte_cnt_q <= '0;
            rsp_left_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef WB_SERIAL_AUTOINC_EN
            last_addr_q <= '0;
`endif
        end else begin
            cmd_q      <= cmd_d;
            req_q      <= req_d;
            byte_cnt_q <= byte_cnt_d;
            rsp_left_q <= rsp_left_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            busy_q     <= busy_d;
`ifdef WB_SERIAL_AUTOINC_EN
            last_addr_q <= last_addr_d;
`endif
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = req_q.we;
    assign o_wb_addr  = {req_q.addr[WORD_W-1:2], 2'b00};
    assign o_wb_data  = req_q.data;
    assign o_wb_sel   = '1;
    assign o_busy     = busy_q;

endmodule
